// File: rtl/flash_op_arbiter_if.sv
// Bundle of the client-side and flash_drive-side signals around flash_op_arbiter.
// The slave modport belongs to the arbiter; the master modport is the surrounding logic.
`timescale 1ns/1ps
interface flash_op_arbiter_if #(
  parameter int P_ADDR_WIDTH = 24,
  parameter int P_NUM_WIDTH  = 9
);
  logic [1:0]              i_c0_operation_type;
  logic [P_ADDR_WIDTH-1:0] i_c0_operation_addr;
  logic [P_NUM_WIDTH-1:0]  i_c0_operation_num;
  logic                    i_c0_operation_valid;
  logic                    o_c0_operation_ready;
  logic [7:0]              i_c0_write_data;
  logic                    i_c0_write_sop;
  logic                    i_c0_write_eop;
  logic                    i_c0_write_valid;
  logic [7:0]              o_c0_read_data;
  logic                    o_c0_read_sop;
  logic                    o_c0_read_eop;
  logic                    o_c0_read_valid;

  logic [1:0]              i_c1_operation_type;
  logic [P_ADDR_WIDTH-1:0] i_c1_operation_addr;
  logic [P_NUM_WIDTH-1:0]  i_c1_operation_num;
  logic                    i_c1_operation_valid;
  logic                    o_c1_operation_ready;
  logic [7:0]              i_c1_write_data;
  logic                    i_c1_write_sop;
  logic                    i_c1_write_eop;
  logic                    i_c1_write_valid;
  logic [7:0]              o_c1_read_data;
  logic                    o_c1_read_sop;
  logic                    o_c1_read_eop;
  logic                    o_c1_read_valid;

  logic [1:0]              o_flash_operation_type;
  logic [P_ADDR_WIDTH-1:0] o_flash_operation_addr;
  logic [P_NUM_WIDTH-1:0]  o_flash_operation_num;
  logic                    o_flash_operation_valid;
  logic                    i_flash_operation_ready;
  logic [7:0]              o_flash_write_data;
  logic                    o_flash_write_sop;
  logic                    o_flash_write_eop;
  logic                    o_flash_write_valid;
  logic [7:0]              i_flash_read_data;
  logic                    i_flash_read_sop;
  logic                    i_flash_read_eop;
  logic                    i_flash_read_valid;

  logic                    o_busy;
  logic                    o_grant;

  modport slave (
    input  i_c0_operation_type, i_c0_operation_addr, i_c0_operation_num, i_c0_operation_valid,
    input  i_c0_write_data, i_c0_write_sop, i_c0_write_eop, i_c0_write_valid,
    output o_c0_operation_ready, o_c0_read_data, o_c0_read_sop, o_c0_read_eop, o_c0_read_valid,
    input  i_c1_operation_type, i_c1_operation_addr, i_c1_operation_num, i_c1_operation_valid,
    input  i_c1_write_data, i_c1_write_sop, i_c1_write_eop, i_c1_write_valid,
    output o_c1_operation_ready, o_c1_read_data, o_c1_read_sop, o_c1_read_eop, o_c1_read_valid,
    output o_flash_operation_type, o_flash_operation_addr, o_flash_operation_num,
    output o_flash_operation_valid,
    input  i_flash_operation_ready,
    output o_flash_write_data, o_flash_write_sop, o_flash_write_eop, o_flash_write_valid,
    input  i_flash_read_data, i_flash_read_sop, i_flash_read_eop, i_flash_read_valid,
    output o_busy, o_grant
  );

  modport master (
    output i_c0_operation_type, i_c0_operation_addr, i_c0_operation_num, i_c0_operation_valid,
    output i_c0_write_data, i_c0_write_sop, i_c0_write_eop, i_c0_write_valid,
    input  o_c0_operation_ready, o_c0_read_data, o_c0_read_sop, o_c0_read_eop, o_c0_read_valid,
    output i_c1_operation_type, i_c1_operation_addr, i_c1_operation_num, i_c1_operation_valid,
    output i_c1_write_data, i_c1_write_sop, i_c1_write_eop, i_c1_write_valid,
    input  o_c1_operation_ready, o_c1_read_data, o_c1_read_sop, o_c1_read_eop, o_c1_read_valid,
    input  o_flash_operation_type, o_flash_operation_addr, o_flash_operation_num,
    input  o_flash_operation_valid,
    output i_flash_operation_ready,
    input  o_flash_write_data, o_flash_write_sop, o_flash_write_eop, o_flash_write_valid,
    output i_flash_read_data, i_flash_read_sop, i_flash_read_eop, i_flash_read_valid,
    input  o_busy, o_grant
  );
endinterface

// File: rtl/flash_op_arbiter.sv
// Two-client arbiter sharing one flash_drive operation port and its write/read streams.
// Optional macro FLASH_ARB_RR_EN: round-robin arbitration; undefined gives client 0 fixed priority.
`timescale 1ns/1ps
module flash_op_arbiter #(
  parameter int P_ADDR_WIDTH = 24,
  parameter int P_NUM_WIDTH  = 9
) (
  input logic               i_clk,
  input logic               i_rst,
  flash_op_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2} state_t;

  state_t                  state;
  logic [1:0]              op_type_r;
  logic [P_ADDR_WIDTH-1:0] op_addr_r;
  logic [P_NUM_WIDTH-1:0]  op_num_r;
  logic                    op_valid_r;
  logic                    busy_r;
  logic                    grant_r;
  logic                    saw_low_r;

  logic [7:0] c0_rd_data_p0, c1_rd_data_p0;
  logic       c0_rd_sop_p0,  c1_rd_sop_p0;
  logic       c0_rd_eop_p0,  c1_rd_eop_p0;
  logic       c0_rd_vld_p0,  c1_rd_vld_p0;

  logic req0, req1, arb_fire, win, wr_active;
  logic [1:0]              win_type;
  logic [P_ADDR_WIDTH-1:0] win_addr;
  logic [P_NUM_WIDTH-1:0]  win_num;

  assign req0     = bus.i_c0_operation_valid;
  assign req1     = bus.i_c1_operation_valid;
  assign arb_fire = (state == IDLE) && !i_rst && bus.i_flash_operation_ready && (req0 || req1);

`ifdef FLASH_ARB_RR_EN
  // Pointer holds the last client served; on a tie the other client goes next.
  logic last_r;
  assign win = (req0 && req1) ? ~last_r : req1;
`else
  assign win = ~req0;
`endif

  assign win_type = win ? bus.i_c1_operation_type : bus.i_c0_operation_type;
  assign win_addr = win ? bus.i_c1_operation_addr : bus.i_c0_operation_addr;
  assign win_num  = win ? bus.i_c1_operation_num  : bus.i_c0_operation_num;

  assign bus.o_c0_operation_ready = arb_fire && !win;
  assign bus.o_c1_operation_ready = arb_fire &&  win;

  assign bus.o_flash_operation_type  = op_type_r;
  assign bus.o_flash_operation_addr  = op_addr_r;
  assign bus.o_flash_operation_num   = op_num_r;
  assign bus.o_flash_operation_valid = op_valid_r;
  assign bus.o_busy                  = busy_r;
  assign bus.o_grant                 = grant_r;

  // Write stream follows the owner for the whole operation; framing is muted while idle.
  assign wr_active              = (state != IDLE);
  assign bus.o_flash_write_data  = grant_r ? bus.i_c1_write_data : bus.i_c0_write_data;
  assign bus.o_flash_write_sop   = wr_active && (grant_r ? bus.i_c1_write_sop   : bus.i_c0_write_sop);
  assign bus.o_flash_write_eop   = wr_active && (grant_r ? bus.i_c1_write_eop   : bus.i_c0_write_eop);
  assign bus.o_flash_write_valid = wr_active && (grant_r ? bus.i_c1_write_valid : bus.i_c0_write_valid);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      op_type_r  <= '0;
      op_addr_r  <= '0;
      op_num_r   <= '0;
      op_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      grant_r    <= 1'b0;
      saw_low_r  <= 1'b0;
`ifdef FLASH_ARB_RR_EN
      last_r     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_fire) begin
            op_type_r  <= win_type;
            op_addr_r  <= win_addr;
            op_num_r   <= win_num;
            op_valid_r <= 1'b1;
            busy_r     <= 1'b1;
            grant_r    <= win;
`ifdef FLASH_ARB_RR_EN
            last_r     <= win;
`endif
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.i_flash_operation_ready) begin
            op_valid_r <= 1'b0;
            saw_low_r  <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Ready is still high in the acceptance cycle; completion is the first rise after a low.
          if (!bus.i_flash_operation_ready) begin
            saw_low_r <= 1'b1;
          end else if (saw_low_r) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p0: read stream registered once and steered to the owner
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      c0_rd_data_p0 <= '0;
      c0_rd_sop_p0  <= 1'b0;
      c0_rd_eop_p0  <= 1'b0;
      c0_rd_vld_p0  <= 1'b0;
      c1_rd_data_p0 <= '0;
      c1_rd_sop_p0  <= 1'b0;
      c1_rd_eop_p0  <= 1'b0;
      c1_rd_vld_p0  <= 1'b0;
    end else begin
      c0_rd_data_p0 <= grant_r ? 8'h00 : bus.i_flash_read_data;
      c0_rd_sop_p0  <= !grant_r && bus.i_flash_read_sop;
      c0_rd_eop_p0  <= !grant_r && bus.i_flash_read_eop;
      c0_rd_vld_p0  <= !grant_r && bus.i_flash_read_valid;
      c1_rd_data_p0 <= grant_r ? bus.i_flash_read_data : 8'h00;
      c1_rd_sop_p0  <= grant_r && bus.i_flash_read_sop;
      c1_rd_eop_p0  <= grant_r && bus.i_flash_read_eop;
      c1_rd_vld_p0  <= grant_r && bus.i_flash_read_valid;
    end
  end

  assign bus.o_c0_read_data  = c0_rd_data_p0;
  assign bus.o_c0_read_sop   = c0_rd_sop_p0;
  assign bus.o_c0_read_eop   = c0_rd_eop_p0;
  assign bus.o_c0_read_valid = c0_rd_vld_p0;
  assign bus.o_c1_read_data  = c1_rd_data_p0;
  assign bus.o_c1_read_sop   = c1_rd_sop_p0;
  assign bus.o_c1_read_eop   = c1_rd_eop_p0;
  assign bus.o_c1_read_valid = c1_rd_vld_p0;

endmodule

// File: doc/flash_op_arbiter.md
# flash_op_arbiter

Two-client arbiter in front of `flash_drive`. It lets two independent user-side masters share the single flash operation port and the write/read data streams. Requests are granted one at a time. The grant is held until `flash_drive` reports the operation complete. It sits between the user logic (for example `user_gen_data` instances) and `flash_drive`, and exposes one `flash_drive`-style user interface per client.

## Interface
Parameters:
- `P_ADDR_WIDTH`, 24, operation address width.
- `P_NUM_WIDTH`, 9, byte-count width (max 256 bytes per operation).

Ports (N = 0, 1; one set of client ports per N):
- `i_clk`  in  1  single system clock; all logic is on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_cN_operation_type`  in  2  client N operation type (passed through, not decoded).
- `i_cN_operation_addr`  in  P_ADDR_WIDTH  client N address.
- `i_cN_operation_num`  in  P_NUM_WIDTH  client N byte count.
- `i_cN_operation_valid`  in  1  client N request valid.
- `o_cN_operation_ready`  out  1  client N request accepted this cycle.
- `i_cN_write_data`/`_sop`/`_eop`/`_valid`  in  8/1/1/1  client N write stream.
- `o_cN_read_data`/`_sop`/`_eop`/`_valid`  out  8/1/1/1  client N read stream.
- `o_flash_operation_type`/`_addr`/`_num`  out  2/P_ADDR_WIDTH/P_NUM_WIDTH  to `flash_drive`.
- `o_flash_operation_valid`  out  1  operation valid to `flash_drive`.
- `i_flash_operation_ready`  in  1  `flash_drive` ready.
- `o_flash_write_data`/`_sop`/`_eop`/`_valid`  out  8/1/1/1  muxed write stream.
- `i_flash_read_data`/`_sop`/`_eop`/`_valid`  in  8/1/1/1  read stream from `flash_drive`.
- `o_busy`  out  1  high in states ISSUE and BUSY.
- `o_grant`  out  1  index of the current or last granted client.

## Operation
- States: IDLE, ISSUE, BUSY.
- **IDLE:**
  - If `i_flash_operation_ready`=1 and at least one `i_cN_operation_valid`=1, select a winner.
  - Assert `o_cN_operation_ready` combinationally for the winner only. This completes the client handshake in that cycle.
  - Capture the winner's type/addr/num into registers, set `o_grant`, go to ISSUE.
- **ISSUE:**
  - Drive `o_flash_operation_valid`=1 with the captured fields.
  - On `o_flash_operation_valid & i_flash_operation_ready`, go to BUSY.
- **BUSY:** `flash_drive` deasserts ready the cycle after acceptance and reasserts it only when the operation is complete, including the last read byte. Exit to IDLE at the first cycle with `i_flash_operation_ready`=1 that follows at least one cycle with `i_flash_operation_ready`=0.
- **Write path:**
  - In ISSUE and BUSY, the granted client's write stream is muxed combinationally to `o_flash_write_*`.
  - The non-granted client's write stream is ignored.
  - In IDLE, `o_flash_write_valid`/`_sop`/`_eop` are forced to 0.
- **Read path:**
  - `i_flash_read_*` is registered once and delivered only to the granted client's `o_cN_read_*`.
  - The other client's read valid/sop/eop stay at 0.
- **Non-granted client:** its `o_cN_operation_ready` stays 0, so its request waits. There is no queueing beyond the client holding valid.

## Timing
- Reset values, all held while `i_rst`=1:
  - state IDLE.
  - `o_flash_operation_valid`/type/addr/num = 0.
  - All `o_cN_operation_ready` = 0; these are gated by `!i_rst`.
  - All `o_cN_read_*` = 0.
  - `o_busy` = 0, `o_grant` = 0.
  - Last-served pointer = 1, so client 0 wins first.
- **Request latency:** client handshake at cycle T; `o_flash_operation_valid`=1 from T+1; state BUSY from the cycle after the flash handshake.
- **Re-arbitration:** if BUSY sees the ready return at cycle R, state is IDLE at R+1. The next client handshake is possible at R+1.
- **Read data latency:** 1 cycle from `i_flash_read_*` to `o_cN_read_*`.
- **Simultaneous requests:** resolved per Configuration. A client that drops valid before its grant is not served.
- **Reset mid-operation:** immediate return to IDLE, all outputs to reset values. `flash_drive` shares the same reset.

## Configuration
- `FLASH_ARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous valid, grant the client not served last.
  - The last-served pointer updates on each client handshake.
- `FLASH_ARB_RR_EN` undefined: fixed priority.
  - Client 0 always wins simultaneous requests.
  - The pointer logic is removed.

## Test plan
- **Single read:** client 0 read, addr 0x000100, num 4.
  - Required: `o_c0_operation_ready` pulses once.
  - Required: the flash port sees type/addr/num unchanged.
  - Required: 4 bytes reach `o_c0_read_*` with sop on the first and eop on the last.
  - Required: `o_c1_read_valid` stays 0 throughout.
- **Simultaneous write, RR on:** both clients assert valid in the same cycle, writes of 8 bytes, `FLASH_ARB_RR_EN` defined.
  - Required: client 0 is granted first, then client 1.
  - Required: `o_flash_write_*` carries only the granted client's bytes, in order.
- **Repeated requests, RR on:** client 0 and client 1 both hold valid for 3 back-to-back operations each. Required: grant order is 0,1,0,1,0,1.
- **Same stimulus, RR off:** `FLASH_ARB_RR_EN` undefined, both clients hold valid. Required: all client-0 operations finish before any client-1 handshake.
- **Back-pressure:** `i_flash_operation_ready` held 0 for 10 cycles during ISSUE.
  - Required: `o_flash_operation_valid` stays 1 with stable fields.
  - Required: no client ready is asserted.
- **Reset mid-operation:** `i_rst` pulsed while in BUSY.
  - Required: next cycle all outputs are at reset values and state is IDLE.
  - Required: a subsequent client 0 request is served normally.
